pipe_hazard_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage RV32 pipeline; sits beside the ID stage.

---
 rtl/pipe_hazard_unit.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline.
// A DEPTH-entry shift scoreboard records each instruction that leaves ID:
// its destination register, whether it writes the RF, and whether it is a load.
// Each ID source operand is served by the youngest in-flight producer of its
// register. That producer's result comes from stage_data once the producer is
// ready. If it is not ready yet, ID stalls. An EX redirect flushes IF_ID and
// ID_EX. A flush overrides a stall.
module pipe_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_RD   = 2,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 0,
    parameter int LOAD_RDY = 1
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst,
    input  logic                     id_valid,
    input  logic [NUM_RD*5-1:0]      id_rs,
    input  logic [NUM_RD-1:0]        id_rs_used,
    input  logic [NUM_RD*XLEN-1:0]   id_rD,
    input  logic [4:0]               id_wR,
    input  logic                     id_we,
    input  logic                     id_is_load,
    input  logic                     ex_redirect,
    input  logic [DEPTH*XLEN-1:0]    stage_data,
    output logic [NUM_RD*XLEN-1:0]   id_opnd,
    output logic [NUM_RD-1:0]        fwd_hit,
    output logic                     hold_pc,
    output logic                     hold_ifid,
    output logic                     bubble_idex,
    output logic                     flush_ifid,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Scoreboard: index 0 = EX, DEPTH-1 = WB
    logic [DEPTH-1:0]      sb_valid_q, sb_valid_d;
    logic [DEPTH-1:0][4:0] sb_wr_q,    sb_wr_d;
    logic [DEPTH-1:0]      sb_we_q,    sb_we_d;
    logic [DEPTH-1:0]      sb_ld_q,    sb_ld_d;

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic [NUM_RD-1:0] pend;
    logic              stall;
    logic              flush;

    // Per-port operand select: youngest matching producer wins; forward if ready, else flag pending
    always_comb begin
        logic [4:0]      rs_p;
        logic            found;
        logic            rdy;
        logic [XLEN-1:0] sel_data;
        id_opnd  = id_rD;
        fwd_hit  = '0;
        pend     = '0;
        rs_p     = '0;
        found    = 1'b0;
        rdy      = 1'b0;
        sel_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rs_p     = id_rs[5*p +: 5];
            found    = 1'b0;
            rdy      = 1'b0;
            sel_data = '0;
            // Walk oldest to youngest so the youngest match is the one left standing
            for (int k = DEPTH-1; k >= 0; k--) begin
                if (sb_valid_q[k] && sb_we_q[k] && (sb_wr_q[k] == rs_p) && (rs_p != 5'd0)) begin
                    found    = 1'b1;
                    rdy      = (k >= (sb_ld_q[k] ? LOAD_RDY : ALU_RDY));
                    sel_data = stage_data[k*XLEN +: XLEN];
                end
            end
            if (id_rs_used[p] && found) begin
                if (rdy) begin
                    id_opnd[p*XLEN +: XLEN] = sel_data;
                    fwd_hit[p]              = 1'b1;
                end else begin
                    pend[p] = 1'b1;
                end
            end
        end
    end

    // Pipeline control: the redirect flush overrides the load-use stall
    always_comb begin
        stall       = id_valid && (|pend);
        flush       = ex_redirect;
        flush_ifid  = flush;
        bubble_idex = flush || stall;
        hold_pc     = stall && !flush;
        hold_ifid   = stall && !flush;
    end

    // Next scoreboard state: shift toward WB; a stalled or flushed ID enters as a bubble
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_wr_d    = sb_wr_q;
        sb_we_d    = sb_we_q;
        sb_ld_d    = sb_ld_q;
        for (int k = 1; k < DEPTH; k++) begin
            sb_valid_d[k] = sb_valid_q[k-1];
            sb_wr_d[k]    = sb_wr_q[k-1];
            sb_we_d[k]    = sb_we_q[k-1];
            sb_ld_d[k]    = sb_ld_q[k-1];
        end
        sb_valid_d[0] = id_valid && !stall && !flush;
        sb_wr_d[0]    = id_wR;
        sb_we_d[0]    = id_we;
        sb_ld_d[0]    = id_is_load;
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sb_valid_q  <= '0;
            sb_wr_q     <= '0;
            sb_we_q     <= '0;
            sb_ld_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_valid_q  <= sb_valid_d;
            sb_wr_q     <= sb_wr_d;
            sb_we_q     <= sb_we_d;
            sb_ld_q     <= sb_ld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with default parameters.
module tb_pipe_hazard_unit;

    logic         cpu_clk = 1'b0;
    logic         cpu_rst;
    logic         id_valid;
    logic [9:0]   id_rs;
    logic [1:0]   id_rs_used;
    logic [63:0]  id_rD;
    logic [4:0]   id_wR;
    logic         id_we;
    logic         id_is_load;
    logic         ex_redirect;
    logic [95:0]  stage_data;
    logic [63:0]  id_opnd;
    logic [1:0]   fwd_hit;
    logic         hold_pc;
    logic         hold_ifid;
    logic         bubble_idex;
    logic         flush_ifid;
    logic [31:0]  stall_cnt;
    logic [31:0]  flush_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RD0 = 32'h0000_0A0A;
    localparam logic [31:0] RD1 = 32'h0000_0B0B;

    pipe_hazard_unit dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rD       (id_rD),
        .id_wR       (id_wR),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .stage_data  (stage_data),
        .id_opnd     (id_opnd),
        .fwd_hit     (fwd_hit),
        .hold_pc     (hold_pc),
        .hold_ifid   (hold_ifid),
        .bubble_idex (bubble_idex),
        .flush_ifid  (flush_ifid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] wr, input logic we, input logic ld,
                          input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                          input logic redir);
        id_valid    = v;
        id_wR       = wr;
        id_we       = we;
        id_is_load  = ld;
        id_rs       = {r1, r0};
        id_rs_used  = used;
        ex_redirect = redir;
    endtask

    initial begin
        cpu_rst    = 1'b0;
        id_rD      = {RD1, RD0};
        stage_data = '0;
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11, 1'b0);

        // Reset state
        tick();
        tick();
        #2;
        chk("rst_hold_pc",  {31'd0, hold_pc},     32'd0);
        chk("rst_bubble",   {31'd0, bubble_idex}, 32'd0);
        chk("rst_flush",    {31'd0, flush_ifid},  32'd0);
        chk("rst_fwd_hit",  {30'd0, fwd_hit},     32'd0);
        chk("rst_opnd0",    id_opnd[31:0],        RD0);
        chk("rst_stall_cnt", stall_cnt,           32'd0);
        chk("rst_flush_cnt", flush_cnt,           32'd0);
        cpu_rst = 1'b1;

        // 1: ALU result forwarded from EX
        tick(); set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01, 1'b0);
        stage_data = {32'h0, 32'h0, 32'h11};
        #2;
        chk("t1_fwd_hit", {30'd0, fwd_hit}, 32'd1);
        chk("t1_opnd0",   id_opnd[31:0],    32'h11);
        chk("t1_opnd1",   id_opnd[63:32],   RD1);
        chk("t1_hold_pc", {31'd0, hold_pc}, 32'd0);

        // 2: load-use stall for exactly one cycle, then forward from MEM
        tick(); set_id(1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd6, 2'b10, 1'b0);
        stage_data = '0;
        #2;
        chk("t2_hold_pc",   {31'd0, hold_pc},     32'd1);
        chk("t2_hold_ifid", {31'd0, hold_ifid},   32'd1);
        chk("t2_bubble",    {31'd0, bubble_idex}, 32'd1);
        chk("t2_fwd_stall", {30'd0, fwd_hit},     32'd0);
        chk("t2_cnt_before", stall_cnt,           32'd0);
        tick();
        stage_data = {32'h0, 32'hDEAD_BEEF, 32'h0};
        #2;
        chk("t2_hold_after", {31'd0, hold_pc},     32'd0);
        chk("t2_bub_after",  {31'd0, bubble_idex}, 32'd0);
        chk("t2_opnd1",      id_opnd[63:32],       32'hDEAD_BEEF);
        chk("t2_fwd_hit",    {30'd0, fwd_hit},     32'd2);
        chk("t2_stall_cnt",  stall_cnt,            32'd1);

        // 3: youngest of two pending writers wins
        tick(); set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 2'b01, 1'b0);
        stage_data = {32'h2, 32'h0, 32'h1};
        #2;
        chk("t3_opnd0",   id_opnd[31:0],    32'h1);
        chk("t3_fwd_hit", {30'd0, fwd_hit}, 32'd1);

        // 4: x0 never forwarded; unused port never stalls
        tick(); set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b01, 1'b0);
        stage_data = {32'h0, 32'h0, 32'h5};
        #2;
        chk("t4_x0_fwd",  {30'd0, fwd_hit}, 32'd0);
        chk("t4_x0_opnd", id_opnd[31:0],    RD0);
        tick(); set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, 2'b00, 1'b0);
        #2;
        chk("t4_unused_hold",   {31'd0, hold_pc},     32'd0);
        chk("t4_unused_bubble", {31'd0, bubble_idex}, 32'd0);
        chk("t4_unused_opnd",   id_opnd[31:0],        RD0);

        // 5: redirect overrides load-use stall
        tick(); set_id(1'b1, 5'd10, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd10, 5'd0, 2'b01, 1'b1);
        #2;
        chk("t5_flush_ifid", {31'd0, flush_ifid},  32'd1);
        chk("t5_bubble",     {31'd0, bubble_idex}, 32'd1);
        chk("t5_hold_pc",    {31'd0, hold_pc},     32'd0);
        chk("t5_hold_ifid",  {31'd0, hold_ifid},   32'd0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 5'd0, 2'b01, 1'b0);
        stage_data = {32'h0, 32'h88, 32'h77};
        #2;
        chk("t5_opnd_lw",   id_opnd[31:0], 32'h88);
        chk("t5_flush_cnt", flush_cnt,     32'd1);
        chk("t5_stall_cnt", stall_cnt,     32'd1);
        // Redirect with no stall: the ID writer must still be dropped
        tick(); set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1);
        #2;
        chk("t5b_flush_ifid", {31'd0, flush_ifid}, 32'd1);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd11, 5'd0, 2'b01, 1'b0);
        #2;
        chk("t5b_fwd_hit",   {30'd0, fwd_hit}, 32'd0);
        chk("t5b_opnd0",     id_opnd[31:0],    RD0);
        chk("t5b_flush_cnt", flush_cnt,        32'd2);

        // 6: asynchronous reset in the middle of a stall
        tick(); set_id(1'b1, 5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd12, 5'd0, 2'b01, 1'b0);
        #2;
        chk("t6_pre_hold", {31'd0, hold_pc}, 32'd1);
        cpu_rst = 1'b0;
        #1;
        chk("t6_hold_pc",   {31'd0, hold_pc},     32'd0);
        chk("t6_bubble",    {31'd0, bubble_idex}, 32'd0);
        chk("t6_flush",     {31'd0, flush_ifid},  32'd0);
        chk("t6_fwd_hit",   {30'd0, fwd_hit},     32'd0);
        chk("t6_opnd0",     id_opnd[31:0],        RD0);
        chk("t6_stall_cnt", stall_cnt,            32'd0);
        chk("t6_flush_cnt", flush_cnt,            32'd0);
        tick();
        tick();
        cpu_rst = 1'b1;
        #2;
        chk("t6_post_hold", {31'd0, hold_pc}, 32'd0);

        // Counter saturation
        tick(); set_id(1'b1, 5'd13, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        release dut.flush_cnt_q;
        tick(); set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd13, 5'd0, 2'b01, 1'b0);
        #2;
        chk("sat_stalling", {31'd0, hold_pc}, 32'd1);
        tick(); set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1);
        #2;
        chk("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        tick(); set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        #2;
        chk("sat_flush_cnt", flush_cnt, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
